// File: rtl/vic20_pkg.sv
// Shared VIC-20 definitions: SPI address spaces, control-register bits,
// RAM-arbiter state encoding and the buffered SPI request.
`default_nettype none

package vic20_pkg;

  localparam logic [7:0] SPACE_RAM  = 8'h00;
  localparam logic [7:0] SPACE_CTRL = 8'hFF;

  localparam int CTRL_RESET_BIT = 0;
  localparam int CTRL_HALT_BIT  = 1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_PEND  = 2'd1,
    ARB_ISSUE = 2'd2,
    ARB_CAP   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
  } spi_req_t;

endpackage

`default_nettype wire

// File: rtl/cpu_phase_counter.sv
// Tracks the position inside the CPU period and decodes the CPU write
// strobe and the SPI issue window for the RAM arbiter.
`default_nettype none

module cpu_phase_counter #(
  parameter int CLK_PER_CPU = 25,
  parameter int PW          = $clog2(CLK_PER_CPU + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_clken_i,
  input  logic cpu_we_i,
  input  logic halted_i,
  output logic cpu_wr_o,
  output logic issue_ok_o
);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (cpu_clken_i) begin
      phase_d = PW'(1);
    end else if (phase_q < PW'(CLK_PER_CPU)) begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PW'(CLK_PER_CPU);
    end else begin
      phase_q <= phase_d;
    end
  end

  assign cpu_wr_o = (phase_q == PW'(1)) && cpu_we_i && !halted_i;

  // Judged on the next cycle's phase: a pending request moves to ISSUE
  // only if that ISSUE cycle itself lands inside [2, CLK_PER_CPU-3].
  assign issue_ok_o = halted_i ||
                      ((phase_d >= PW'(2)) && (phase_d <= PW'(CLK_PER_CPU - 3)));

endmodule

`default_nettype wire

// File: rtl/vic20_ram_arbiter.sv
// Shares dpram port A between the registered 6502 bus and the SPI slave,
// slotting SPI accesses into idle CPU cycles; also owns the control register.
`default_nettype none

module vic20_ram_arbiter
  import vic20_pkg::*;
#(
  parameter int CLK_PER_CPU = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_clken,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic        spi_wr,
  input  logic        spi_rd,
  input  logic [31:0] spi_addr,
  input  logic [7:0]  spi_di,
  output logic [7:0]  spi_do,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  cpu_control,
  output logic        spi_busy,
  output logic        overrun
);

  arb_state_e state_q, state_d;
  spi_req_t   req_q, req_d;
  logic [7:0] spi_do_q, spi_do_d;
  logic [7:0] cpu_control_q, cpu_control_d;
  logic       overrun_q, overrun_d;

  logic       w_cpu_wr;
  logic       w_issue_ok;
  logic       w_halted;
  logic       w_ram_stb;
  logic       w_ctrl_wr;
  logic       w_unused;

  assign w_halted  = cpu_control_q[CTRL_HALT_BIT];
  assign w_ram_stb = (spi_wr || spi_rd) && (spi_addr[31:24] == SPACE_RAM);
  assign w_ctrl_wr = spi_wr && (spi_addr[31:24] == SPACE_CTRL);
  assign w_unused  = ^spi_addr[23:16];

  cpu_phase_counter #(
    .CLK_PER_CPU (CLK_PER_CPU)
  ) u_phase (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_clken_i (cpu_clken),
    .cpu_we_i    (cpu_we),
    .halted_i    (w_halted),
    .cpu_wr_o    (w_cpu_wr),
    .issue_ok_o  (w_issue_ok)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    spi_do_d      = spi_do_q;
    cpu_control_d = w_ctrl_wr ? spi_di : cpu_control_q;
    overrun_d     = overrun_q || (w_ram_stb && (state_q != ARB_IDLE));
    ram_addr      = cpu_addr;
    ram_din       = cpu_dout;
    ram_we        = w_cpu_wr;

    unique case (state_q)
      ARB_IDLE: begin
        if (w_ram_stb) begin
          // spi_wr wins when both strobes arrive together
          req_d.addr = spi_addr[15:0];
          req_d.data = spi_di;
          req_d.we   = spi_wr;
          state_d    = ARB_PEND;
        end
      end
      ARB_PEND: begin
        if (w_issue_ok) begin
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        ram_addr = req_q.addr;
        ram_din  = req_q.data;
        ram_we   = req_q.we;
        state_d  = req_q.we ? ARB_IDLE : ARB_CAP;
      end
      ARB_CAP: begin
        spi_do_d = ram_dout;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      req_q         <= '0;
      spi_do_q      <= 8'h00;
      cpu_control_q <= 8'h00;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      spi_do_q      <= spi_do_d;
      cpu_control_q <= cpu_control_d;
      overrun_q     <= overrun_d;
    end
  end

  assign spi_do      = spi_do_q;
  assign cpu_control = cpu_control_q;
  assign overrun     = overrun_q;
  assign spi_busy    = (state_q != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vic20_ram_arbiter.sv
// Randomised bench for vic20_ram_arbiter with a timestamp-based reference
// model of request issue/complete times and a golden copy of RAM.
`default_nettype none

module tb_vic20_ram_arbiter;

  localparam int CLK = 25;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_clken;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        spi_wr, spi_rd;
  logic [31:0] spi_addr;
  logic [7:0]  spi_di;
  logic [7:0]  spi_do;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [7:0]  cpu_control;
  logic        spi_busy;
  logic        overrun;

  vic20_ram_arbiter #(.CLK_PER_CPU(CLK)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_clken   (cpu_clken),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout),
    .cpu_we      (cpu_we),
    .spi_wr      (spi_wr),
    .spi_rd      (spi_rd),
    .spi_addr    (spi_addr),
    .spi_di      (spi_di),
    .spi_do      (spi_do),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .cpu_control (cpu_control),
    .spi_busy    (spi_busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5C;
  endfunction

  // dpram port A: synchronous read, read-before-write
  logic [7:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:65535];
  int          cur;
  int          ph;
  logic [7:0]  ctrl_m, spi_do_m;
  bit          ovr_m;
  bit          req_active, req_issued, req_we;
  int          req_strobe, req_issue, req_end;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  bit          cap_pending;
  logic [7:0]  cap_val;
  int          cap_cyc;

  int n_checks = 0;
  int n_errors = 0;
  int div;
  bit chk_cpu_rd;
  int obs_cpu_ph, obs_spi_ph, n1234;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cur);
    end
  endtask

  task automatic model_reset();
    ph          = CLK;
    ctrl_m      = 8'h00;
    spi_do_m    = 8'h00;
    ovr_m       = 1'b0;
    req_active  = 1'b0;
    req_issued  = 1'b0;
    cap_pending = 1'b0;
  endtask

  // Expected port A drive for the current cycle.
  task automatic exp_port(output logic e_we, output logic [15:0] e_a, output logic [7:0] e_d);
    if (req_active && req_issued && cur == req_issue) begin
      e_we = req_we; e_a = req_addr; e_d = req_data;
    end else begin
      e_we = (ph == 1) && cpu_we && !ctrl_m[1];
      e_a  = cpu_addr;
      e_d  = cpu_dout;
    end
  endtask

  task automatic check_outputs();
    logic e_we; logic [15:0] e_a; logic [7:0] e_d;
    exp_port(e_we, e_a, e_d);
    check_eq("ram_we", ram_we, e_we);
    check_eq("ram_addr", ram_addr, e_a);
    check_eq("ram_din", ram_din, e_d);
    check_eq("spi_busy", spi_busy, req_active);
    check_eq("spi_do", spi_do, spi_do_m);
    check_eq("cpu_control", cpu_control, ctrl_m);
    check_eq("overrun", overrun, ovr_m);
    if (chk_cpu_rd && cpu_clken && !ctrl_m[1])
      check_eq("cpu_rd_8000", ram_dout, ref_mem[16'h8000]);
    if (ram_we === 1'b1 && ram_addr == 16'h1000) obs_cpu_ph = ph;
    if (ram_we === 1'b1 && ram_addr == 16'h2000 && ram_din == 8'h22) obs_spi_ph = ph;
    if (ram_we === 1'b1 && ram_addr == 16'h1234) n1234++;
  endtask

  // Advance the model across one rising edge using this cycle's inputs.
  task automatic model_update();
    logic e_we; logic [15:0] e_a; logic [7:0] e_d;
    bit busy;
    int nph;
    if (!reset_n) begin
      model_reset();
    end else begin
      exp_port(e_we, e_a, e_d);
      if (cap_pending && cur == cap_cyc) begin
        spi_do_m = cap_val;
        cap_pending = 1'b0;
      end
      if (req_active && req_issued && cur == req_issue && !req_we) begin
        cap_pending = 1'b1;
        cap_val     = ref_mem[req_addr];
        cap_cyc     = cur + 1;
      end
      if (e_we) ref_mem[e_a] = e_d;
      busy = req_active;
      nph  = cpu_clken ? 1 : ((ph < CLK) ? ph + 1 : CLK);
      // Eligible from strobe+2: issue cycle must sit in the window, or follow a halted cycle.
      if (req_active && !req_issued && cur >= req_strobe + 1 &&
          (ctrl_m[1] || (nph >= 2 && nph <= CLK - 3))) begin
        req_issued = 1'b1;
        req_issue  = cur + 1;
        req_end    = cur + 1 + (req_we ? 0 : 1);
      end
      if (req_active && req_issued && cur == req_end) req_active = 1'b0;
      if ((spi_wr || spi_rd) && spi_addr[31:24] == 8'h00) begin
        if (busy) begin
          ovr_m = 1'b1;
        end else begin
          req_active = 1'b1; req_issued = 1'b0; req_strobe = cur;
          req_addr = spi_addr[15:0]; req_data = spi_di; req_we = spi_wr;
        end
      end
      if (spi_wr && spi_addr[31:24] == 8'hFF) ctrl_m = spi_di;
      ph = nph;
    end
    cur++;
  endtask

  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
    spi_wr = 1'b0;
    spi_rd = 1'b0;
    div = (div == CLK - 1) ? 0 : div + 1;
    cpu_clken = (div == 0);
  endtask

  task automatic spi_strobe(input bit wr, input bit rd, input logic [31:0] a, input logic [7:0] d);
    spi_wr = wr; spi_rd = rd; spi_addr = a; spi_di = d;
    step();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 60 && ph != p; i++) step();
    check_eq("wait_phase", ph, p);
  endtask

  task automatic random_block(input int cycles, input bit cpu_random);
    int r;
    for (int i = 0; i < cycles; i++) begin
      if (cpu_random) begin
        cpu_addr = 16'h2000 + 16'($urandom_range(0, 255));
        cpu_we   = ($urandom_range(0, 3) == 0);
        cpu_dout = 8'($urandom);
      end
      spi_addr = {8'h00, 8'h00, 16'h2000 + 16'($urandom_range(0, 15))};
      spi_di   = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 19);
        if (r < 8)       spi_rd = 1'b1;
        else if (r < 14) spi_wr = 1'b1;
        else if (r < 16) begin spi_wr = 1'b1; spi_rd = 1'b1; end
        else if (r < 18) begin spi_wr = 1'b1; spi_addr[31:24] = 8'h05; end
        else if (cpu_random) begin spi_wr = 1'b1; spi_addr = 32'hFF00_0000; spi_di = 8'($urandom & 3); end
        else begin spi_rd = 1'b1; spi_addr[31:24] = 8'hFF; end
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    cur = 0; div = 1; cpu_clken = 1'b0; chk_cpu_rd = 1'b0;
    obs_cpu_ph = -1; obs_spi_ph = -1; n1234 = 0;
    cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0;
    spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = 32'h0; spi_di = 8'h00;
    reset_n = 1'b1;
    #1;
    @(negedge clk);
    do_reset(4);
    check_eq("reset_spi_do", spi_do, 8'h00);

    // Halted: write then read back through the arbiter
    spi_strobe(1'b1, 1'b0, 32'hFF00_0000, 8'h02);
    spi_strobe(1'b1, 1'b0, 32'h0000_1234, 8'h5A);
    repeat (3) step();
    spi_strobe(1'b0, 1'b1, 32'h0000_1234, 8'h00);
    repeat (3) step();
    check_eq("halt_rd_data", spi_do, 8'h5A);
    check_eq("halt_wr_pulses", n1234, 1);

    // Running: CPU write at phase 1, SPI write strobed at phase 23
    spi_strobe(1'b1, 1'b0, 32'hFF00_0000, 8'h00);
    wait_phase(23);
    cpu_addr = 16'h1000; cpu_dout = 8'h11; cpu_we = 1'b1;
    spi_strobe(1'b1, 1'b0, 32'h0000_2000, 8'h22);
    repeat (4) step();
    cpu_we = 1'b0;
    repeat (5) step();
    check_eq("cpu_wr_phase", obs_cpu_ph, 1);
    check_eq("spi_wr_phase", obs_spi_ph, 2);
    check_eq("mem_1000", mem[16'h1000], 8'h11);
    check_eq("mem_2000", mem[16'h2000], 8'h22);

    // Running CPU reads of 0x8000 with random SPI traffic
    cpu_addr = 16'h8000;
    repeat (30) step();
    chk_cpu_rd = 1'b1;
    random_block(700, 1'b0);
    chk_cpu_rd = 1'b0;
    random_block(700, 1'b1);
    cpu_we = 1'b0;
    spi_strobe(1'b1, 1'b0, 32'hFF00_0000, 8'h00);
    repeat (30) step();

    // Overrun: second strobe one cycle after the first
    do_reset(2);
    spi_strobe(1'b1, 1'b0, 32'h0000_3000, 8'h77);
    spi_strobe(1'b1, 1'b0, 32'h0000_3001, 8'h88);
    repeat (40) step();
    check_eq("ovr_set", overrun, 1'b1);
    check_eq("ovr_first", mem[16'h3000], 8'h77);
    check_eq("ovr_second", mem[16'h3001], init_byte(16'h3001));
    repeat (30) step();
    check_eq("ovr_sticky", overrun, 1'b1);
    do_reset(2);
    check_eq("ovr_cleared", overrun, 1'b0);

    // Control-space write and a foreign-space write
    spi_strobe(1'b1, 1'b0, 32'hFF00_0000, 8'h02);
    check_eq("ctrl_next", cpu_control, 8'h02);
    spi_strobe(1'b1, 1'b0, 32'h0500_1234, 8'hEE);
    repeat (30) step();
    check_eq("space05_mem", mem[16'h1234], 8'h5A);

    // Reset while a request is pending
    spi_strobe(1'b1, 1'b0, 32'hFF00_0000, 8'h01);
    spi_strobe(1'b0, 1'b1, 32'h0000_3000, 8'h00);
    repeat (30) step();
    check_eq("pre_rd", spi_do, 8'h77);
    wait_phase(23);
    spi_strobe(1'b1, 1'b0, 32'h0000_4000, 8'h99);
    check_eq("pend_busy", spi_busy, 1'b1);
    do_reset(3);
    check_eq("rst_busy", spi_busy, 1'b0);
    check_eq("rst_ctrl", cpu_control, 8'h00);
    check_eq("rst_spi_do", spi_do, 8'h00);
    repeat (60) step();
    check_eq("rst_no_write", mem[16'h4000], init_byte(16'h4000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
